// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared state, op-select and response-error encodings for the    |
// |            ALU issue controller.                                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMB     = 2'd1,
        MOD_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_AND = 3'b001;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b011;
    localparam logic [2:0] SEL_XOR = 3'b100;
    localparam logic [2:0] SEL_SHL = 3'b101;
    localparam logic [2:0] SEL_SHR = 3'b110;
    localparam logic [2:0] SEL_MOD = 3'b111;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Counter width able to hold any load value up to max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_timer                                                 |
// | Purpose  : Loadable saturating down-counter with terminal-count flag.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_issue_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] r_count;

    // Stops at zero so a stalled wait can never wrap back to a large count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_ctrl                                                  |
// | Purpose  : Issues one request at a time to the 32-bit ALU, waits for the   |
// |            result (fixed settle or start/done) and returns it.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int COMB_WAIT = 1,
    parameter int TIMEOUT   = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_sel,
    input  logic             req_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    output logic             alu_cin,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic [1:0]       rsp_err
);

    localparam int c_cnt_max = (TIMEOUT > COMB_WAIT) ? TIMEOUT : COMB_WAIT;
    localparam int c_cnt_w   = cnt_width(c_cnt_max);

    // The timer reaches zero on the last cycle of the wait, hence the -1.
    localparam logic [c_cnt_w-1:0] c_comb_load = c_cnt_w'(COMB_WAIT - 1);
    localparam logic [c_cnt_w-1:0] c_mod_load  = c_cnt_w'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_capture;
    logic [c_cnt_w-1:0] w_load_val;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_cout_next;
    logic [1:0]         w_err_next;
    logic               w_tc;
    logic               w_timer_en;

    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2:0]         r_alu_sel;
    logic               r_alu_cin;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_cout;
    logic [1:0]         r_rsp_err;

    assign w_timer_en = (r_state == COMB) || (r_state == MOD_WAIT);

    alu_issue_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_accept),
        .load_val (w_load_val),
        .en       (w_timer_en),
        .tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_load_val   = c_comb_load;
        w_res_next   = alu_result;
        w_cout_next  = alu_cout;
        w_err_next   = ERR_OK;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_sel != SEL_MOD) begin
                        w_state_next = COMB;
                    end else if (req_b == '0) begin
                        // Divide-by-zero is answered directly; the ALU never starts.
                        w_state_next = RESP;
                        w_capture    = 1'b1;
                        w_res_next   = '0;
                        w_cout_next  = 1'b0;
                        w_err_next   = ERR_DIV0;
                    end else begin
                        w_state_next = MOD_WAIT;
                        w_load_val   = c_mod_load;
                    end
                end
            end
            COMB: begin
                if (w_tc) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end
            end
            MOD_WAIT: begin
                if (alu_done) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end else if (w_tc) begin
                    w_capture    = 1'b1;
                    w_res_next   = '0;
                    w_cout_next  = 1'b0;
                    w_err_next   = ERR_TIMEOUT;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand registers change only on acceptance; the response is frozen until handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_alu_cin    <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= ERR_OK;
        end else begin
            if (w_accept) begin
                r_alu_a   <= req_a;
                r_alu_b   <= req_b;
                r_alu_sel <= req_sel;
                r_alu_cin <= req_cin;
            end
            if (w_capture) begin
                r_rsp_result <= w_res_next;
                r_rsp_cout   <= w_cout_next;
                r_rsp_err    <= w_err_next;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign alu_start  = (r_state == MOD_WAIT);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign alu_cin    = r_alu_cin;
    assign rsp_result = r_rsp_result;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator-side controller for the 32-bit ALU.
- Accepts operation requests (a, b, sel) over a valid/ready handshake and drives the ALU operand and select inputs.
- Combinational ops: waits a fixed settle time. Sequential modulo op (sel=3'b111): runs the start/done handshake.
- Returns the captured result and carry-out over a valid/ready response channel, with divide-by-zero and timeout protection.

Parameters:
- WIDTH, 32, operand/result width.
- COMB_WAIT, 1, cycles a combinational result is allowed to settle before capture (>=1).
- TIMEOUT, 256, max cycles to wait for alu_done after start before aborting (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_sel  input  3  ALU op select; 3'b111 = modulo (multi-cycle).
- req_cin  input  1  carry-in.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_sel  output  3  to ALU sel.
- alu_cin  output  1  to ALU c_in.
- alu_start  output  1  modulo start.
- alu_result  input  WIDTH  from ALU result.
- alu_cout  input  1  from ALU c_out.
- alu_done  input  1  modulo complete.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  captured result.
- rsp_cout  output  1  captured carry-out.
- rsp_err  output  2  00 ok, 01 mod-by-zero, 10 timeout.

Behaviour:
- Reset (synchronous, active-high, clk and reset as named above): state=IDLE; req_ready=1; all other outputs 0 (alu_a/b/sel/cin, alu_start, rsp_*); counters 0. Reset overrides any state, including MOD_WAIT: alu_start drops on the next edge and any pending response is discarded.
- States:
  - IDLE: req_ready=1. On req_valid, latch the operands into alu_* registers and set req_ready=0.
    - sel!=111 -> COMB.
    - sel=111 and b==0 -> RESP with err=01, result=0, cout=0; the ALU is never started.
    - sel=111 and b!=0 -> MOD_WAIT with alu_start=1.
  - COMB: count COMB_WAIT cycles. On the last one, capture alu_result and alu_cout, err=00 -> RESP. Latency from accept to rsp_valid = COMB_WAIT+1 cycles.
  - MOD_WAIT: alu_start stays 1. On the first cycle alu_done=1, capture result and cout, err=00, drop alu_start -> RESP.
    - If the wait counter reaches TIMEOUT with no alu_done: drop alu_start, result=0, err=10 -> RESP.
    - alu_done is ignored in every other state.
  - RESP: rsp_valid=1, with rsp_* held stable until rsp_valid & rsp_ready. On handshake -> IDLE, rsp_valid=0, req_ready=1 on the following cycle. No request is accepted while in RESP (single outstanding).
- alu_a, alu_b, alu_sel and alu_cin hold their last latched values in all states after capture; they change only on acceptance.
- alu_start is 1 only in MOD_WAIT, so there is a guaranteed low cycle between consecutive modulo ops.
- The wait counter is sized clog2(TIMEOUT)+1 and saturates; it never wraps.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding (IDLE, COMB, MOD_WAIT, RESP);
  - op select constants (SEL_AND…SEL_MOD=3'b111);
  - rsp_err codes (ERR_OK, ERR_DIV0, ERR_TIMEOUT).
- One sub-module: alu_issue_timer, a loadable saturating down-counter used for both COMB_WAIT and TIMEOUT, with a terminal-count output.
- All other logic (FSM, capture registers) stays in the top module.

Test Plan:
- a=100, b=60, sel=000 (add), rsp_ready=1 -> rsp_valid 2 cycles after accept, result=160, err=00.
- a=100, b=60, sel=010 (sub) -> result=40, err=00.
- Back-to-back requests -> second accepted only after the first rsp handshake.
- a=100, b=6, sel=111, ALU model asserts done after 17 cycles -> alu_start high exactly 17 cycles, result=4, err=00.
- a=100, b=0, sel=111 -> alu_start never asserts, rsp_valid 1 cycle after accept, result=0, err=01.
- sel=111, b=6, alu_done tied 0 -> alu_start deasserts after TIMEOUT=256 cycles, rsp err=10, result=0.
- Modulo in progress: assert reset for 1 cycle in MOD_WAIT -> next edge alu_start=0, rsp_valid=0, req_ready=1; a later alu_done pulse is ignored.
- Result with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_result stable for all 10 cycles, req_ready=0 throughout.
